// File: rtl/audio_sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : audio_sample_packer
// Description : Stereo sample FIFO feeding a 4-slot staging set consumed by
//               the HDMI audio sample packet generator (clk_pixel domain).
//               Optional build macro AUDIO_PACKER_DROP_OLDEST_EN: a write
//               into a full FIFO discards the oldest entry instead of the
//               incoming sample.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_packer #(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                                    clk_pixel,
  input  logic                                    reset,
  input  logic                                    sample_valid,
  input  logic [AUDIO_BIT_WIDTH-1:0]              sample_left,
  input  logic [AUDIO_BIT_WIDTH-1:0]              sample_right,
  input  logic                                    packet_grant,
  output logic [3:0][1:0][AUDIO_BIT_WIDTH-1:0]    stage_word,
  output logic [3:0]                              stage_present,
  output logic [$clog2(FIFO_DEPTH):0]             fifo_level,
  output logic                                    overflow,
  output logic                                    underflow
);

  localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL  = FIFO_DEPTH[c_PTR_W:0];

  localparam logic [0:0] c_FILL = 1'b0;
  localparam logic [0:0] c_HOLD = 1'b1;

  // FIFO entry: [0] = left, [1] = right (same layout as one stage slot)
  logic [1:0][AUDIO_BIT_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_level;
  logic [0:0]         r_state;
  logic [0:0]         w_state_next;

  logic       w_full;
  logic       w_empty;
  logic       w_pop_fill;
  logic       w_write;
  logic       w_drop;
  logic       w_rd_adv;
  logic [1:0] w_slot;

  assign w_full  = (r_level == c_FULL);
  assign w_empty = (r_level == '0);

  // Next free slot; the present bits always fill from bit 0 upward
  always_comb begin
    w_slot = 2'd0;
    if (stage_present[0]) w_slot = 2'd1;
    if (stage_present[1]) w_slot = 2'd2;
    if (stage_present[2]) w_slot = 2'd3;
  end

  // FSM state register
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) r_state <= c_FILL;
    else       r_state <= w_state_next;
  end

  // FSM next state: a grant always returns to FILL; the 4th pop enters HOLD
  always_comb begin
    w_state_next = r_state;
    if (packet_grant)
      w_state_next = c_FILL;
    else if (w_pop_fill && (w_slot == 2'd3))
      w_state_next = c_HOLD;
  end

  // FSM outputs: pop/write/discard decisions for this cycle
  always_comb begin
    w_pop_fill = (r_state == c_FILL) && !w_empty && !packet_grant;
`ifdef AUDIO_PACKER_DROP_OLDEST_EN
    // A full write consumes the head; if the stage is popping it this
    // cycle anyway, that pop doubles as the discard.
    w_write = sample_valid;
    w_drop  = sample_valid && w_full && !w_pop_fill;
`else
    // Full is judged before any same-cycle pop, so the write is lost.
    w_write = sample_valid && !w_full;
    w_drop  = 1'b0;
`endif
    w_rd_adv = w_pop_fill || w_drop;
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk_pixel) begin
    if (w_write) r_mem[r_wr_ptr] <= {sample_right, sample_left};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_write)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_adv) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_write, w_rd_adv})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Staging set: cleared the cycle after a grant, otherwise filled slot by slot
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      stage_word    <= '0;
      stage_present <= '0;
    end else if (packet_grant) begin
      stage_word    <= '0;
      stage_present <= '0;
    end else if (w_pop_fill) begin
      stage_word[w_slot]    <= r_mem[r_rd_ptr];
      stage_present[w_slot] <= 1'b1;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (sample_valid && w_full)                overflow  <= 1'b1;
      if (packet_grant && (stage_present == '0)) underflow <= 1'b1;
    end
  end

  assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_sample_packer
// Description : Self-checking bench for audio_sample_packer: directed vector
//               table, hand-written corner sequences and a randomized run
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_sample_packer;

  localparam int W = 16;
  localparam int D = 16;

  logic                  clk_pixel;
  logic                  reset;
  logic                  sample_valid;
  logic [W-1:0]          sample_left;
  logic [W-1:0]          sample_right;
  logic                  packet_grant;
  logic [3:0][1:0][W-1:0] stage_word;
  logic [3:0]            stage_present;
  logic [$clog2(D):0]    fifo_level;
  logic                  overflow;
  logic                  underflow;

  audio_sample_packer #(.AUDIO_BIT_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk_pixel    (clk_pixel),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .packet_grant (packet_grant),
    .stage_word   (stage_word),
    .stage_present(stage_present),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] l;
  } samp_t;

  samp_t m_fifo[$];
  samp_t m_stage[$];
  logic  m_of;
  logic  m_uf;

  task automatic model_reset();
    m_fifo.delete();
    m_stage.delete();
    m_of = 1'b0;
    m_uf = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] l,
                            input logic [W-1:0] r, input logic g);
    bit    was_full;
    bit    pop;
    samp_t s;
    was_full = (m_fifo.size() == D);
    pop      = !g && (m_stage.size() < 4) && (m_fifo.size() > 0);
    if (g) begin
      if (m_stage.size() == 0) m_uf = 1'b1;
      m_stage.delete();
    end else if (pop) begin
      m_stage.push_back(m_fifo.pop_front());
    end
    s.l = l;
    s.r = r;
    if (v) begin
      if (!was_full) begin
        m_fifo.push_back(s);
      end else begin
        m_of = 1'b1;
`ifdef AUDIO_PACKER_DROP_OLDEST_EN
        if (!pop) void'(m_fifo.pop_front());
        m_fifo.push_back(s);
`endif
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0][1:0][W-1:0] ew;
    logic [3:0]             ep;
    ew = '0;
    ep = '0;
    for (int i = 0; i < m_stage.size(); i++) begin
      ew[i][0] = m_stage[i].l;
      ew[i][1] = m_stage[i].r;
      ep[i]    = 1'b1;
    end
    chk({tag, ".present"},   128'(stage_present), 128'(ep));
    chk({tag, ".word"},      128'(stage_word),    128'(ew));
    chk({tag, ".level"},     128'(fifo_level),    128'(m_fifo.size()));
    chk({tag, ".overflow"},  128'(overflow),      128'(m_of));
    chk({tag, ".underflow"}, 128'(underflow),     128'(m_uf));
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later
  task automatic step(input logic v, input logic [W-1:0] l,
                      input logic [W-1:0] r, input logic g);
    sample_valid = v;
    sample_left  = l;
    sample_right = r;
    packet_grant = g;
    @(posedge clk_pixel);
    #1;
    model_step(v, l, r, g);
    sample_valid = 1'b0;
    packet_grant = 1'b0;
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    packet_grant = 1'b0;
    sample_left  = '0;
    sample_right = '0;
    reset        = 1'b1;
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         v;
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic         g;
    logic [3:0]   e_present;
    logic [4:0]   e_level;
    logic         e_of;
    logic         e_uf;
  } vec_t;

  vec_t vec[13];

  int base;

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    packet_grant = 1'b0;
    sample_left  = '0;
    sample_right = '0;

    // four strobes fill the stage, grant clears it, two more, grant, empty grant
    vec[0]  = '{1'b1, 16'h0001, 16'h1001, 1'b0, 4'b0000, 5'd1, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 16'h0002, 16'h1002, 1'b0, 4'b0001, 5'd1, 1'b0, 1'b0};
    vec[2]  = '{1'b1, 16'h0003, 16'h1003, 1'b0, 4'b0011, 5'd1, 1'b0, 1'b0};
    vec[3]  = '{1'b1, 16'h0004, 16'h1004, 1'b0, 4'b0111, 5'd1, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 4'b1111, 5'd0, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'b0000, 5'd0, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 16'h0005, 16'h1005, 1'b0, 4'b0000, 5'd1, 1'b0, 1'b0};
    vec[7]  = '{1'b1, 16'h0006, 16'h1006, 1'b0, 4'b0001, 5'd1, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 4'b0011, 5'd0, 1'b0, 1'b0};
    vec[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'b0000, 5'd0, 1'b0, 1'b0};
    vec[10] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'b0000, 5'd0, 1'b0, 1'b1};
    vec[11] = '{1'b1, 16'h0007, 16'h1007, 1'b0, 4'b0000, 5'd1, 1'b0, 1'b1};
    vec[12] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 4'b0001, 5'd0, 1'b0, 1'b1};

    do_reset();
    chk("reset.present",   128'(stage_present), 128'(0));
    chk("reset.word",      128'(stage_word),    128'(0));
    chk("reset.level",     128'(fifo_level),    128'(0));
    chk("reset.overflow",  128'(overflow),      128'(0));
    chk("reset.underflow", 128'(underflow),     128'(0));

    for (int i = 0; i < 13; i++) begin
      step(vec[i].v, vec[i].l, vec[i].r, vec[i].g);
      chk($sformatf("vec%0d.present", i),   128'(stage_present), 128'(vec[i].e_present));
      chk($sformatf("vec%0d.level", i),     128'(fifo_level),    128'(vec[i].e_level));
      chk($sformatf("vec%0d.overflow", i),  128'(overflow),      128'(vec[i].e_of));
      chk($sformatf("vec%0d.underflow", i), 128'(underflow),     128'(vec[i].e_uf));
      check_model($sformatf("vec%0d.model", i));
      if (i == 4) begin
        for (int s = 0; s < 4; s++) begin
          chk($sformatf("fill.slot%0d.l", s), 128'(stage_word[s][0]), 128'(s + 1));
          chk($sformatf("fill.slot%0d.r", s), 128'(stage_word[s][1]), 128'(16'h1001 + s));
        end
      end
    end

    // overflow with 20 + 1 strobes
    do_reset();
    for (int i = 1; i <= 20; i++) step(1'b1, W'(i), W'(16'h1000 + i), 1'b0);
    chk("burst.level",    128'(fifo_level),    128'(16));
    chk("burst.overflow", 128'(overflow),      128'(0));
    chk("burst.present",  128'(stage_present), 128'(4'b1111));
    for (int s = 0; s < 4; s++)
      chk($sformatf("burst.slot%0d.l", s), 128'(stage_word[s][0]), 128'(s + 1));
    step(1'b1, W'(21), W'(16'h1015), 1'b0);
    chk("burst21.overflow", 128'(overflow),   128'(1));
    chk("burst21.level",    128'(fifo_level), 128'(16));
    step(1'b0, '0, '0, 1'b1);
    chk("burst.grant.present", 128'(stage_present), 128'(0));
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0);
`ifdef AUDIO_PACKER_DROP_OLDEST_EN
    base = 6;
`else
    base = 5;
`endif
    for (int s = 0; s < 4; s++)
      chk($sformatf("refill.slot%0d.l", s), 128'(stage_word[s][0]), 128'(base + s));
    check_model("refill.model");

    // grant and strobe together with stage full, FIFO empty
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i), W'(i), 1'b0);
    step(1'b0, '0, '0, 1'b0);
    chk("gw.pre.present", 128'(stage_present), 128'(4'b1111));
    chk("gw.pre.level",   128'(fifo_level),    128'(0));
    step(1'b1, 16'hAAAA, 16'h5555, 1'b1);
    chk("gw.clear.present", 128'(stage_present), 128'(0));
    chk("gw.clear.level",   128'(fifo_level),    128'(1));
    step(1'b0, '0, '0, 1'b0);
    chk("gw.next.present", 128'(stage_present),    128'(4'b0001));
    chk("gw.next.slot0l",  128'(stage_word[0][0]), 128'(16'hAAAA));
    check_model("gw.model");

    // asynchronous reset mid-FILL
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i), W'(i), 1'b1);
    step(1'b0, '0, '0, 1'b0);
    step(1'b1, W'(5), W'(5), 1'b0);
    chk("mid.present", 128'(stage_present), 128'(4'b0011));
    chk("mid.level",   128'(fifo_level),    128'(3));
    #2;
    reset = 1'b1;
    #1;
    chk("async.present",   128'(stage_present), 128'(0));
    chk("async.word",      128'(stage_word),    128'(0));
    chk("async.level",     128'(fifo_level),    128'(0));
    chk("async.underflow", 128'(underflow),     128'(0));
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, W'(16'h0100 + i), W'(16'h0200 + i), 1'b0);
      check_model($sformatf("resume%0d", i));
    end

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic v;
      logic g;
      if (((i / 100) % 2) == 0) begin
        v = ($urandom_range(0, 9) < 8);
        g = ($urandom_range(0, 15) == 0);
      end else begin
        v = ($urandom_range(0, 9) < 3);
        g = ($urandom_range(0, 5) == 0);
      end
      step(v, W'($urandom), W'($urandom), g);
      check_model($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
